vie_id_stage: RTL and testbench
===============================

Name: vie_id_stage

Overview:
- Decode stage of the 5-stage MIPS pipeline.
- Consumes the fetch-stage bus (fsbus) and returns `ds_allowin` and the branch bus (brbus) to fetch.
- Holds the 32x32 GPR file, detects RAW hazards against EXE/MEM, and resolves branches in decode with one architectural delay slot.
- Emits a decoded bus (dsbus) to EXE.

Parameters:
- none

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- es_allowin  in  1  EXE can accept this cycle
- ds_allowin  out  1  decode can accept fsbus this cycle
- fsbus_i  in  65  [64] fs_to_ds_valid, [63:32] pc, [31:0] inst
- brbus_o  out  33  [32] br_taken, [31:0] br_target
- dsbus_o  out  148  [147] ds_to_es_valid, [146:115] pc, [114:103] alu_op one-hot, [102] mem_load, [101] mem_store, [100:96] dest, [95:64] src1, [63:32] src2, [31:0] st_data
- wsbus_i  in  38  [37] rf_we, [36:32] rf_waddr, [31:0] rf_wdata (from WB)
- es_dest_i  in  5  dest of valid EXE instruction; 0 = none
- ms_dest_i  in  5  dest of valid MEM instruction; 0 = none

Behaviour:
- Reset values:
  - ds_valid_r=0; pc_r=0; inst_r=0.
  - ds_allowin=1; brbus_o=0; dsbus_o[147]=0.
  - GPR contents are not reset; r0 always reads 0.
- Handshake:
  - ds_allowin = !ds_valid_r || (ds_ready_go && es_allowin).
  - When ds_allowin=1: ds_valid_r <= fsbus_i[64]; {pc_r, inst_r} <= fsbus_i[63:0] whenever fsbus_i[64]=1.
  - ds_to_es_valid = ds_valid_r && ds_ready_go.
  - Latency: 1 cycle fsbus -> dsbus.
- Hazard:
  - ds_ready_go = 0 iff ds_valid_r and a source register actually used by the instruction is nonzero and equals es_dest_i or ms_dest_i.
  - A stall holds pc_r/inst_r and drops ds_allowin.
- Register file:
  - 2 read ports (rs, rt) and 1 write port on the clock edge; writes to r0 are ignored.
  - Same-cycle write bypass: if rf_we and rf_waddr==raddr!=0, the read returns rf_wdata.
  - No stall is needed against WB.
- Decoded instructions:
  - R-type: ADDU, SUBU, SLT, SLTU, AND, OR, XOR, NOR, SLL, SRL, SRA, JR.
  - I-type: ADDIU, LUI, LW, SW, BEQ, BNE.
  - Jumps: J, JAL.
  - Any other encoding is a NOP: alu_op=0, dest=0, load/store=0.
- alu_op one-hot bit order [0..11]: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
- Operands:
  - src1 = rs value; for shifts src1 = {27'b0, sa}; for JAL src1 = pc_r.
  - src2: rt value for R-type; sext(imm) for ADDIU/LW/SW; zero-extended imm for LUI; 8 for JAL.
  - For SLL/SRL/SRA the value shifted is rt, carried in src2.
  - st_data = rt value.
- dest:
  - rd for R-type (0 for JR); rt for ADDIU/LUI/LW.
  - 31 for JAL; 0 for SW/BEQ/BNE/J.
- Branch targets:
  - BEQ/BNE: pc_r + 4 + (sext(imm) << 2), mod 2^32.
  - J/JAL: {pc_r+4 [31:28], instr_index, 2'b00}.
  - JR: rs value.
- br_taken is asserted only when ds_valid_r && ds_ready_go && es_allowin && the branch/jump is taken; it is combinational and valid for exactly that cycle.
  - The instruction already in fetch (delay slot) still executes; decode never squashes it.
- A stalled branch never asserts br_taken; fetch is frozen by ds_allowin=0.
- Reset mid-operation clears ds_valid_r; any in-flight decoded instruction is discarded.

Test Plan:
- Reset, then fsbus valid pc=bfc00000 inst=24010005 (addiu r1,r0,5) -> next cycle dsbus valid, alu_op=001, src1=0, src2=5, dest=1.
- WB writes r2=0x1234 while decode reads r2 via `addu r3,r2,r0` in the same cycle -> src1=0x1234 (bypass).
- es_dest_i=1 with decode holding `addu r4,r1,r0` -> ds_allowin=0, ds_to_es_valid=0; es_dest_i->0 -> issues next cycle with pc unchanged.
- BEQ r0,r0,+3 at pc=bfc00010 -> br_taken=1 for one cycle, target=bfc00020; delay slot bfc00014 then decodes normally.
- JAL idx=0x0100000 at pc=bfc00020 -> target=b0400000, dest=31, src1=bfc00020, src2=8, add one-hot.
- es_allowin=0 while decode holds a taken BNE -> br_taken=0 and state held; taken pulse appears in the cycle es_allowin rises.

Source files
------------

// File: rtl/vie_id_stage.sv
// Decode stage of the 5-stage MIPS pipeline: holds the GPR file, detects RAW
// hazards against EXE/MEM, resolves branches (one delay slot) and emits dsbus.
module vie_id_stage (
  input  logic         clock,
  input  logic         reset,
  input  logic         es_allowin,
  output logic         ds_allowin,
  input  logic [64:0]  fsbus_i,
  output logic [32:0]  brbus_o,
  output logic [147:0] dsbus_o,
  input  logic [37:0]  wsbus_i,
  input  logic [4:0]   es_dest_i,
  input  logic [4:0]   ms_dest_i
);

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpLui     = 6'h0f;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpSw      = 6'h2b;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2a;
  localparam logic [5:0] FnSltu = 6'h2b;

  // One-hot alu_op bit positions
  localparam int unsigned AluAdd  = 0;
  localparam int unsigned AluSub  = 1;
  localparam int unsigned AluSlt  = 2;
  localparam int unsigned AluSltu = 3;
  localparam int unsigned AluAnd  = 4;
  localparam int unsigned AluNor  = 5;
  localparam int unsigned AluOr   = 6;
  localparam int unsigned AluXor  = 7;
  localparam int unsigned AluSll  = 8;
  localparam int unsigned AluSrl  = 9;
  localparam int unsigned AluSra  = 10;
  localparam int unsigned AluLui  = 11;

  typedef enum logic [1:0] {Src2Rt, Src2Sext, Src2Zext, Src2Eight} src2_sel_e;

  logic        ds_valid_q, ds_valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] rf_q [32];

  logic        fs_valid;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;
  logic [25:0] instr_index;
  logic [31:0] rs_val, rt_val;

  logic [11:0] alu_op;
  logic        mem_load, mem_store;
  logic [4:0]  dest;
  logic        use_rs, use_rt;
  logic        sel_sa, sel_pc;
  src2_sel_e   src2_sel;
  logic        is_beq, is_bne, is_jump, is_jr;

  logic [31:0] src1, src2;
  logic [31:0] imm_sext, pc_plus4, br_target;
  logic        br_cond, br_taken;
  logic        rs_hit, rt_hit, ds_ready_go, ds_to_es_valid;

  assign fs_valid = fsbus_i[64];
  assign rf_we    = wsbus_i[37];
  assign rf_waddr = wsbus_i[36:32];
  assign rf_wdata = wsbus_i[31:0];

  assign opcode      = inst_q[31:26];
  assign rs          = inst_q[25:21];
  assign rt          = inst_q[20:16];
  assign rd          = inst_q[15:11];
  assign sa          = inst_q[10:6];
  assign funct       = inst_q[5:0];
  assign imm         = inst_q[15:0];
  assign instr_index = inst_q[25:0];

  // GPR write port; r0 is never written so it stays architecturally zero
  always_ff @(posedge clock) begin
    if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Read ports with same-cycle WB bypass, so no stall against WB is needed
  assign rs_val = (rs == 5'd0) ? 32'd0 :
                  (rf_we && (rf_waddr == rs)) ? rf_wdata : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 :
                  (rf_we && (rf_waddr == rt)) ? rf_wdata : rf_q[rt];

  // Instruction decode; unrecognised encodings fall through as a NOP
  always_comb begin
    alu_op    = '0;
    mem_load  = 1'b0;
    mem_store = 1'b0;
    dest      = 5'd0;
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    sel_sa    = 1'b0;
    sel_pc    = 1'b0;
    src2_sel  = Src2Rt;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_jump   = 1'b0;
    is_jr     = 1'b0;
    unique case (opcode)
      OpSpecial: begin
        unique case (funct)
          FnAddu:  alu_op[AluAdd]  = 1'b1;
          FnSubu:  alu_op[AluSub]  = 1'b1;
          FnSlt:   alu_op[AluSlt]  = 1'b1;
          FnSltu:  alu_op[AluSltu] = 1'b1;
          FnAnd:   alu_op[AluAnd]  = 1'b1;
          FnNor:   alu_op[AluNor]  = 1'b1;
          FnOr:    alu_op[AluOr]   = 1'b1;
          FnXor:   alu_op[AluXor]  = 1'b1;
          FnSll:   alu_op[AluSll]  = 1'b1;
          FnSrl:   alu_op[AluSrl]  = 1'b1;
          FnSra:   alu_op[AluSra]  = 1'b1;
          FnJr: begin
            is_jr  = 1'b1;
            use_rs = 1'b1;
          end
          default: ;
        endcase
        if (alu_op != '0) begin
          dest   = rd;
          use_rt = 1'b1;
          sel_sa = alu_op[AluSll] | alu_op[AluSrl] | alu_op[AluSra];
          use_rs = ~sel_sa;
        end
      end
      OpAddiu: begin
        alu_op[AluAdd] = 1'b1;
        dest           = rt;
        use_rs         = 1'b1;
        src2_sel       = Src2Sext;
      end
      OpLui: begin
        alu_op[AluLui] = 1'b1;
        dest           = rt;
        src2_sel       = Src2Zext;
      end
      OpLw: begin
        alu_op[AluAdd] = 1'b1;
        mem_load       = 1'b1;
        dest           = rt;
        use_rs         = 1'b1;
        src2_sel       = Src2Sext;
      end
      OpSw: begin
        alu_op[AluAdd] = 1'b1;
        mem_store      = 1'b1;
        use_rs         = 1'b1;
        use_rt         = 1'b1;
        src2_sel       = Src2Sext;
      end
      OpBeq: begin
        is_beq = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OpBne: begin
        is_bne = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OpJ: is_jump = 1'b1;
      OpJal: begin
        // Link value is pc + 8 computed by EXE's adder
        alu_op[AluAdd] = 1'b1;
        is_jump        = 1'b1;
        dest           = 5'd31;
        sel_pc         = 1'b1;
        src2_sel       = Src2Eight;
      end
      default: ;
    endcase
  end

  // Operand selection
  always_comb begin
    src1 = rs_val;
    if (sel_sa) begin
      src1 = {27'd0, sa};
    end else if (sel_pc) begin
      src1 = pc_q;
    end
    unique case (src2_sel)
      Src2Sext:  src2 = imm_sext;
      Src2Zext:  src2 = {16'd0, imm};
      Src2Eight: src2 = 32'd8;
      default:   src2 = rt_val;
    endcase
  end

  assign imm_sext = {{16{imm[15]}}, imm};
  assign pc_plus4 = pc_q + 32'd4;

  // Branch target and condition
  always_comb begin
    br_target = pc_plus4;
    if (is_beq || is_bne) begin
      br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    end else if (is_jump) begin
      br_target = {pc_plus4[31:28], instr_index, 2'b00};
    end else if (is_jr) begin
      br_target = rs_val;
    end
  end

  assign br_cond = is_jump | is_jr | (is_beq & (rs_val == rt_val)) |
                   (is_bne & (rs_val != rt_val));

  // RAW hazard against in-flight EXE/MEM destinations
  assign rs_hit = use_rs && (rs != 5'd0) && ((rs == es_dest_i) || (rs == ms_dest_i));
  assign rt_hit = use_rt && (rt != 5'd0) && ((rt == es_dest_i) || (rt == ms_dest_i));

  assign ds_ready_go    = !(ds_valid_q && (rs_hit || rt_hit));
  assign ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid_q && ds_ready_go;
  // Fire only on the cycle the branch actually leaves decode
  assign br_taken       = ds_valid_q && ds_ready_go && es_allowin && br_cond;

  assign brbus_o = br_taken ? {1'b1, br_target} : 33'd0;
  assign dsbus_o = {ds_to_es_valid, pc_q, alu_op, mem_load, mem_store, dest,
                    src1, src2, rt_val};

  // Pipeline register next state: accept fsbus only when decode can move
  always_comb begin
    ds_valid_d = ds_valid_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    if (ds_allowin) begin
      ds_valid_d = fs_valid;
      if (fs_valid) begin
        pc_d   = fsbus_i[63:32];
        inst_d = fsbus_i[31:0];
      end
    end
  end

  // Pipeline register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      ds_valid_q <= 1'b0;
      pc_q       <= 32'd0;
      inst_q     <= 32'd0;
    end else begin
      ds_valid_q <= ds_valid_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
    end
  end

endmodule

// File: tb/tb_vie_id_stage.sv
// Directed testbench for vie_id_stage.
module tb_vie_id_stage;

  logic         clock;
  logic         reset;
  logic         es_allowin;
  logic         ds_allowin;
  logic [64:0]  fsbus_i;
  logic [32:0]  brbus_o;
  logic [147:0] dsbus_o;
  logic [37:0]  wsbus_i;
  logic [4:0]   es_dest_i;
  logic [4:0]   ms_dest_i;

  int n_checks;
  int n_fails;

  logic [115:0] exp_hi;
  logic [51:0]  exp_ctl;

  vie_id_stage dut (
    .clock      (clock),
    .reset      (reset),
    .es_allowin (es_allowin),
    .ds_allowin (ds_allowin),
    .fsbus_i    (fsbus_i),
    .brbus_o    (brbus_o),
    .dsbus_o    (dsbus_o),
    .wsbus_i    (wsbus_i),
    .es_dest_i  (es_dest_i),
    .ms_dest_i  (ms_dest_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_fs(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    fsbus_i = {v, pc, inst};
  endtask

  task automatic test_reset;
    reset = 1'b1; es_allowin = 1'b1; fsbus_i = '0; wsbus_i = '0;
    es_dest_i = 5'd0; ms_dest_i = 5'd0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (ds_allowin !== 1'b1) begin
      n_fails++; $display("FAIL reset_allowin: got %0b expected 1", ds_allowin);
    end
    n_checks++;
    if (brbus_o !== 33'd0) begin
      n_fails++; $display("FAIL reset_brbus: got %h expected 0", brbus_o);
    end
    n_checks++;
    if (dsbus_o[147] !== 1'b0) begin
      n_fails++; $display("FAIL reset_dsvalid: got %0b expected 0", dsbus_o[147]);
    end
  endtask

  task automatic test_addiu;
    drive_fs(1'b1, 32'hbfc00000, 32'h24010005);  // addiu r1,r0,5
    tick();
    drive_fs(1'b0, 32'd0, 32'd0);
    @(negedge clock);
    exp_hi = {1'b1, 32'hbfc00000, 12'h001, 1'b0, 1'b0, 5'd1, 32'd0, 32'd5};
    n_checks++;
    if (dsbus_o[147:32] !== exp_hi) begin
      n_fails++; $display("FAIL addiu_bus: got %h expected %h", dsbus_o[147:32], exp_hi);
    end
    n_checks++;
    if (brbus_o !== 33'd0) begin
      n_fails++; $display("FAIL addiu_brbus: got %h expected 0", brbus_o);
    end
    tick();
    @(negedge clock);
    n_checks++;
    if (dsbus_o[147] !== 1'b0) begin
      n_fails++; $display("FAIL addiu_drain: got %0b expected 0", dsbus_o[147]);
    end
  endtask

  task automatic test_bypass;
    drive_fs(1'b1, 32'hbfc00004, 32'h00401821);  // addu r3,r2,r0
    tick();
    drive_fs(1'b0, 32'd0, 32'd0);
    wsbus_i = {1'b1, 5'd2, 32'h00001234};
    @(negedge clock);
    exp_hi = {1'b1, 32'hbfc00004, 12'h001, 1'b0, 1'b0, 5'd3, 32'h00001234, 32'd0};
    n_checks++;
    if (dsbus_o[147:32] !== exp_hi) begin
      n_fails++; $display("FAIL bypass_bus: got %h expected %h", dsbus_o[147:32], exp_hi);
    end
    tick();
    wsbus_i = '0;
    drive_fs(1'b1, 32'hbfc00008, 32'h00402821);  // addu r5,r2,r0
    tick();
    drive_fs(1'b0, 32'd0, 32'd0);
    wsbus_i = {1'b1, 5'd0, 32'hffffffff};          // write to r0 must be invisible
    @(negedge clock);
    exp_hi = {1'b1, 32'hbfc00008, 12'h001, 1'b0, 1'b0, 5'd5, 32'h00001234, 32'd0};
    n_checks++;
    if (dsbus_o[147:32] !== exp_hi) begin
      n_fails++; $display("FAIL rf_read_bus: got %h expected %h", dsbus_o[147:32], exp_hi);
    end
    tick();
    wsbus_i = '0;
  endtask

  task automatic test_hazard;
    drive_fs(1'b1, 32'h80000100, 32'h00202021);  // addu r4,r1,r0
    tick();
    drive_fs(1'b1, 32'h80000104, 32'h00000000);
    es_dest_i = 5'd1;
    @(negedge clock);
    n_checks++;
    if ({ds_allowin, dsbus_o[147]} !== 2'b00) begin
      n_fails++; $display("FAIL haz_stall: got allowin/valid %b expected 00",
                          {ds_allowin, dsbus_o[147]});
    end
    tick();
    @(negedge clock);
    n_checks++;
    if ({ds_allowin, dsbus_o[147:115]} !== {1'b0, 1'b0, 32'h80000100}) begin
      n_fails++; $display("FAIL haz_hold: got %h expected %h",
                          {ds_allowin, dsbus_o[147:115]}, {1'b0, 1'b0, 32'h80000100});
    end
    tick();
    es_dest_i = 5'd0;
    @(negedge clock);
    n_checks++;
    if ({ds_allowin, dsbus_o[147:115]} !== {1'b1, 1'b1, 32'h80000100}) begin
      n_fails++; $display("FAIL haz_release: got %h expected %h",
                          {ds_allowin, dsbus_o[147:115]}, {1'b1, 1'b1, 32'h80000100});
    end
    tick();
    drive_fs(1'b0, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if (dsbus_o[147:115] !== {1'b1, 32'h80000104}) begin
      n_fails++; $display("FAIL haz_next: got %h expected %h",
                          dsbus_o[147:115], {1'b1, 32'h80000104});
    end
    // rt hazard against MEM
    drive_fs(1'b1, 32'h80000200, 32'h00092021);  // addu r4,r0,r9
    tick();
    drive_fs(1'b0, 32'd0, 32'd0);
    ms_dest_i = 5'd9;
    @(negedge clock);
    n_checks++;
    if ({ds_allowin, dsbus_o[147]} !== 2'b00) begin
      n_fails++; $display("FAIL haz_ms_rt: got %b expected 00", {ds_allowin, dsbus_o[147]});
    end
    tick();
    ms_dest_i = 5'd0;
    drive_fs(1'b1, 32'h80000204, 32'h24070001);  // addiu r7,r0,1 (rt is dest only)
    tick();
    drive_fs(1'b0, 32'd0, 32'd0);
    es_dest_i = 5'd7;
    @(negedge clock);
    n_checks++;
    if ({ds_allowin, dsbus_o[147:115]} !== {1'b1, 1'b1, 32'h80000204}) begin
      n_fails++; $display("FAIL haz_unused_src: got %h expected %h",
                          {ds_allowin, dsbus_o[147:115]}, {1'b1, 1'b1, 32'h80000204});
    end
    tick();
    es_dest_i = 5'd0;
  endtask

  task automatic test_beq;
    drive_fs(1'b1, 32'hbfc00010, 32'h10000003);  // beq r0,r0,+3
    tick();
    drive_fs(1'b1, 32'hbfc00014, 32'h00000000);
    @(negedge clock);
    n_checks++;
    if (brbus_o !== {1'b1, 32'hbfc00020}) begin
      n_fails++; $display("FAIL beq_brbus: got %h expected %h", brbus_o, {1'b1, 32'hbfc00020});
    end
    exp_ctl = {1'b1, 32'hbfc00010, 12'h000, 1'b0, 1'b0, 5'd0};
    n_checks++;
    if (dsbus_o[147:96] !== exp_ctl) begin
      n_fails++; $display("FAIL beq_bus: got %h expected %h", dsbus_o[147:96], exp_ctl);
    end
    tick();
    drive_fs(1'b0, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if ({brbus_o, dsbus_o[147:115]} !== {33'd0, 1'b1, 32'hbfc00014}) begin
      n_fails++; $display("FAIL beq_delay_slot: got %h expected %h",
                          {brbus_o, dsbus_o[147:115]}, {33'd0, 1'b1, 32'hbfc00014});
    end
    tick();
  endtask

  task automatic test_jal;
    drive_fs(1'b1, 32'hbfc00020, 32'h0c100000);  // jal 0x0100000
    tick();
    drive_fs(1'b0, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if (brbus_o !== {1'b1, 32'hb0400000}) begin
      n_fails++; $display("FAIL jal_brbus: got %h expected %h", brbus_o, {1'b1, 32'hb0400000});
    end
    exp_hi = {1'b1, 32'hbfc00020, 12'h001, 1'b0, 1'b0, 5'd31, 32'hbfc00020, 32'd8};
    n_checks++;
    if (dsbus_o[147:32] !== exp_hi) begin
      n_fails++; $display("FAIL jal_bus: got %h expected %h", dsbus_o[147:32], exp_hi);
    end
    tick();
  endtask

  task automatic test_decode_misc;
    drive_fs(1'b1, 32'h80000300, 32'h00400008);  // jr r2
    tick();
    drive_fs(1'b1, 32'h80000304, 32'h00024100);  // sll r8,r2,4
    @(negedge clock);
    n_checks++;
    if ({brbus_o, dsbus_o[147], dsbus_o[100:96]} !== {1'b1, 32'h00001234, 1'b1, 5'd0}) begin
      n_fails++; $display("FAIL jr: got %h expected %h", {brbus_o, dsbus_o[147], dsbus_o[100:96]},
                          {1'b1, 32'h00001234, 1'b1, 5'd0});
    end
    tick();
    drive_fs(1'b1, 32'h80000308, 32'hac02fffc);  // sw r2,-4(r0)
    @(negedge clock);
    exp_hi = {1'b1, 32'h80000304, 12'h100, 1'b0, 1'b0, 5'd8, 32'd4, 32'h00001234};
    n_checks++;
    if ({brbus_o, dsbus_o[147:32]} !== {33'd0, exp_hi}) begin
      n_fails++; $display("FAIL sll_bus: got %h expected %h", {brbus_o, dsbus_o[147:32]},
                          {33'd0, exp_hi});
    end
    tick();
    drive_fs(1'b1, 32'h8000030c, 32'hfc000000);  // undefined opcode
    @(negedge clock);
    n_checks++;
    if (dsbus_o !== {1'b1, 32'h80000308, 12'h001, 1'b0, 1'b1, 5'd0, 32'd0, 32'hfffffffc,
                     32'h00001234}) begin
      n_fails++; $display("FAIL sw_bus: got %h expected %h", dsbus_o,
                          {1'b1, 32'h80000308, 12'h001, 1'b0, 1'b1, 5'd0, 32'd0, 32'hfffffffc,
                           32'h00001234});
    end
    tick();
    drive_fs(1'b1, 32'h80000310, 32'h3c09bfc0);  // lui r9,0xbfc0
    @(negedge clock);
    exp_ctl = {1'b1, 32'h8000030c, 12'h000, 1'b0, 1'b0, 5'd0};
    n_checks++;
    if (dsbus_o[147:96] !== exp_ctl) begin
      n_fails++; $display("FAIL nop_bus: got %h expected %h", dsbus_o[147:96], exp_ctl);
    end
    tick();
    drive_fs(1'b1, 32'h80000314, 32'h8c4a0004);  // lw r10,4(r2)
    @(negedge clock);
    exp_hi = {1'b1, 32'h80000310, 12'h800, 1'b0, 1'b0, 5'd9, 32'd0, 32'h0000bfc0};
    n_checks++;
    if (dsbus_o[147:32] !== exp_hi) begin
      n_fails++; $display("FAIL lui_bus: got %h expected %h", dsbus_o[147:32], exp_hi);
    end
    tick();
    drive_fs(1'b0, 32'd0, 32'd0);
    @(negedge clock);
    exp_hi = {1'b1, 32'h80000314, 12'h001, 1'b1, 1'b0, 5'd10, 32'h00001234, 32'd4};
    n_checks++;
    if (dsbus_o[147:32] !== exp_hi) begin
      n_fails++; $display("FAIL lw_bus: got %h expected %h", dsbus_o[147:32], exp_hi);
    end
    tick();
  endtask

  task automatic test_bne_stall;
    es_allowin = 1'b0;
    drive_fs(1'b1, 32'hbfc00040, 32'h1402fffe);  // bne r0,r2,-2
    tick();
    drive_fs(1'b1, 32'hbfc00044, 32'h00000000);
    @(negedge clock);
    n_checks++;
    if ({brbus_o, ds_allowin, dsbus_o[147]} !== {33'd0, 1'b0, 1'b1}) begin
      n_fails++; $display("FAIL bne_blocked: got %h expected %h",
                          {brbus_o, ds_allowin, dsbus_o[147]}, {33'd0, 1'b0, 1'b1});
    end
    tick();
    @(negedge clock);
    n_checks++;
    if ({brbus_o, dsbus_o[146:115]} !== {33'd0, 32'hbfc00040}) begin
      n_fails++; $display("FAIL bne_hold: got %h expected %h", {brbus_o, dsbus_o[146:115]},
                          {33'd0, 32'hbfc00040});
    end
    tick();
    es_allowin = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({brbus_o, ds_allowin} !== {1'b1, 32'hbfc0003c, 1'b1}) begin
      n_fails++; $display("FAIL bne_release: got %h expected %h", {brbus_o, ds_allowin},
                          {1'b1, 32'hbfc0003c, 1'b1});
    end
    tick();
    drive_fs(1'b0, 32'd0, 32'd0);
    @(negedge clock);
    n_checks++;
    if ({brbus_o, dsbus_o[147:115]} !== {33'd0, 1'b1, 32'hbfc00044}) begin
      n_fails++; $display("FAIL bne_delay_slot: got %h expected %h",
                          {brbus_o, dsbus_o[147:115]}, {33'd0, 1'b1, 32'hbfc00044});
    end
    tick();
  endtask

  task automatic test_reset_mid;
    es_allowin = 1'b0;
    drive_fs(1'b1, 32'hbfc00020, 32'h0c100000);  // jal held by EXE back-pressure
    tick();
    drive_fs(1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    es_allowin = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({brbus_o, ds_allowin, dsbus_o[147]} !== {33'd0, 1'b1, 1'b0}) begin
      n_fails++; $display("FAIL reset_mid: got %h expected %h",
                          {brbus_o, ds_allowin, dsbus_o[147]}, {33'd0, 1'b1, 1'b0});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_addiu();
    test_bypass();
    test_hazard();
    test_beq();
    test_jal();
    test_decode_misc();
    test_bne_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
